// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg -- shared definitions for the register file access arbiter.
//
// Contents:
//   - register index constants (IDX_R = 0 ... IDX_TOTAL = 10)
//   - one-hot enable encodings for the default 11-entry register file
//   - arbiter state encoding (arb_state_e)
//
// Configuration macro: RF_ARB_LOCK_EN adds the ST_LOCKED state.
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_REG_COUNT = 11;

    // Register file index map.
    localparam logic [3:0] IDX_R      = 4'd0;
    localparam logic [3:0] IDX_G      = 4'd1;
    localparam logic [3:0] IDX_B      = 4'd2;
    localparam logic [3:0] IDX_A      = 4'd3;
    localparam logic [3:0] IDX_ALPHAR = 4'd4;
    localparam logic [3:0] IDX_ALPHAG = 4'd5;
    localparam logic [3:0] IDX_ALPHAB = 4'd6;
    localparam logic [3:0] IDX_ALPHAP = 4'd7;
    localparam logic [3:0] IDX_ALPHAQ = 4'd8;
    localparam logic [3:0] IDX_SUM    = 4'd9;
    localparam logic [3:0] IDX_TOTAL  = 4'd10;

    // One-hot read/write enable encodings for the default register file.
    localparam logic [RF_REG_COUNT-1:0] EN_NONE   = 11'b000_0000_0000;
    localparam logic [RF_REG_COUNT-1:0] EN_R      = 11'b000_0000_0001;
    localparam logic [RF_REG_COUNT-1:0] EN_G      = 11'b000_0000_0010;
    localparam logic [RF_REG_COUNT-1:0] EN_B      = 11'b000_0000_0100;
    localparam logic [RF_REG_COUNT-1:0] EN_A      = 11'b000_0000_1000;
    localparam logic [RF_REG_COUNT-1:0] EN_ALPHAR = 11'b000_0001_0000;
    localparam logic [RF_REG_COUNT-1:0] EN_ALPHAG = 11'b000_0010_0000;
    localparam logic [RF_REG_COUNT-1:0] EN_ALPHAB = 11'b000_0100_0000;
    localparam logic [RF_REG_COUNT-1:0] EN_ALPHAP = 11'b000_1000_0000;
    localparam logic [RF_REG_COUNT-1:0] EN_ALPHAQ = 11'b001_0000_0000;
    localparam logic [RF_REG_COUNT-1:0] EN_SUM    = 11'b010_0000_0000;
    localparam logic [RF_REG_COUNT-1:0] EN_TOTAL  = 11'b100_0000_0000;

    // ST_IDLE: no grant issued; ST_SERVE: a grant was issued;
    // ST_LOCKED: one requester owns the register file exclusively.
`ifdef RF_ARB_LOCK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1
    } arb_state_e;
`endif

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick -- round-robin one-hot picker.
//
// Ports:
//   req_i  [N-1:0]  request vector
//   ptr_i  [PW-1:0] index of the last granted requester
//   gnt_o  [N-1:0]  one-hot grant; the search starts at ptr_i+1 and wraps
//                   from N-1 to 0. All-zero when req_i is all-zero.
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    always_comb begin
        int   idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        // k = N lands back on ptr_i itself, so the last granted requester
        // is still served when it is the only one asking.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// rf_access_arbiter -- round-robin arbiter giving n_req requesters
// single-port access to a register file with one-hot read/write enables.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   req_valid    per-requester access request
//   req_we       per-requester write (1) / read (0)
//   req_addr     per-requester 4-bit register index, packed n_req x 4
//   req_wdata    per-requester write data, packed n_req x reg_width
//   req_lock     (RF_ARB_LOCK_EN only) per-requester lock request
//   gnt          one-hot grant, combinational; the access is taken this cycle
//   rdata        registered read data
//   rdata_valid  one-hot owner of rdata, one cycle after the read grant
//   addr_err     one-cycle pulse after a granted out-of-range index
//   read_en      one-hot register file read enable
//   write_en     one-hot register file write enable
//   rf_wdata     register file write data
//   rf_rdata     register file read data (combinational from read_en)
//   dbg_state    current FSM state (arb_state_e encoding)
//
// Handshake: a requester holds req_valid with stable req_we/req_addr/
// req_wdata until it sees gnt in the same cycle; the access completes at the
// following rising edge. Dropping req_valid before gnt abandons the request.
//
// Configuration macro: RF_ARB_LOCK_EN -- when defined, a requester granted
// with req_lock=1 keeps exclusive ownership until it is granted with
// req_lock=0.
// ---------------------------------------------------------------------------
module rf_access_arbiter
    import rf_pkg::*;
#(
    parameter int reg_count = 11,
    parameter int reg_width = 12,
    parameter int n_req     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [n_req-1:0]           req_valid,
    input  logic [n_req-1:0]           req_we,
    input  logic [n_req*4-1:0]         req_addr,
    input  logic [n_req*reg_width-1:0] req_wdata,
`ifdef RF_ARB_LOCK_EN
    input  logic [n_req-1:0]           req_lock,
`endif
    output logic [n_req-1:0]           gnt,
    output logic [reg_width-1:0]       rdata,
    output logic [n_req-1:0]           rdata_valid,
    output logic                       addr_err,
    output logic [reg_count-1:0]       read_en,
    output logic [reg_count-1:0]       write_en,
    output logic [reg_width-1:0]       rf_wdata,
    input  logic [reg_width-1:0]       rf_rdata,
    output logic [1:0]                 dbg_state
);

    localparam int PW = (n_req > 2) ? 2 : 1;

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        ptr_q;
    logic [reg_width-1:0] rdata_q;
    logic [n_req-1:0]     rdv_q;
    logic                 err_q;

    logic [n_req-1:0]     req_eff;
    logic [n_req-1:0]     pick;
    logic                 gnt_any;
    logic [PW-1:0]        g_idx;
    logic                 g_we;
    logic [3:0]           g_addr;
    logic [reg_width-1:0] g_wdata;
    logic                 in_range;
    logic [reg_count-1:0] en_vec;

`ifdef RF_ARB_LOCK_EN
    logic [n_req-1:0]     owner_q, owner_d;
    logic                 g_lock;
`endif

    // While locked, only the owner may compete.
    always_comb begin
        req_eff = req_valid;
`ifdef RF_ARB_LOCK_EN
        if (state_q == ST_LOCKED) begin
            req_eff = req_valid & owner_q;
        end
`endif
    end

    rr_pick #(
        .N  (n_req),
        .PW (PW)
    ) u_pick (
        .req_i (req_eff),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    // Grants are combinational, so gate them with reset to keep every
    // output quiet while reset is held.
    assign gnt_any = reset && (|pick);
    assign gnt     = reset ? pick : '0;

    // Select the granted requester's fields.
    always_comb begin
        g_idx   = '0;
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
`ifdef RF_ARB_LOCK_EN
        g_lock  = 1'b0;
`endif
        for (int i = 0; i < n_req; i++) begin
            if (pick[i]) begin
                g_idx   = PW'(i);
                g_we    = req_we[i];
                g_addr  = req_addr[i*4 +: 4];
                g_wdata = req_wdata[i*reg_width +: reg_width];
`ifdef RF_ARB_LOCK_EN
                g_lock  = req_lock[i];
`endif
            end
        end
    end

    assign in_range = int'(g_addr) < reg_count;

    // Register file drive: an out-of-range index still takes the grant but
    // must leave every enable low.
    always_comb begin
        en_vec   = '0;
        read_en  = '0;
        write_en = '0;
        rf_wdata = '0;
        for (int r = 0; r < reg_count; r++) begin
            en_vec[r] = (int'(g_addr) == r);
        end
        if (gnt_any) begin
            rf_wdata = g_wdata;
            if (in_range) begin
                if (g_we) begin
                    write_en = en_vec;
                end else begin
                    read_en = en_vec;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = (|req_valid) ? ST_SERVE : ST_IDLE;
`ifdef RF_ARB_LOCK_EN
        owner_d = owner_q;
        if (state_q == ST_LOCKED) begin
            // Only an owner access with req_lock=0 releases the lock.
            if (!(gnt_any && !g_lock)) begin
                state_d = ST_LOCKED;
            end
        end else if (gnt_any && g_lock) begin
            state_d = ST_LOCKED;
            owner_d = pick;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(n_req - 1);
            rdata_q <= '0;
            rdv_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // While locked the grant always goes to the owner, which is
            // already the pointer value, so the pointer stays frozen.
            if (gnt_any) begin
                ptr_q <= g_idx;
            end
            rdv_q <= '0;
            err_q <= gnt_any && !in_range;
            if (gnt_any && in_range && !g_we) begin
                rdata_q <= rf_rdata;
                rdv_q   <= pick;
            end
        end
    end

`ifdef RF_ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= '0;
        end else begin
            owner_q <= owner_d;
        end
    end
`endif

    assign rdata       = rdata_q;
    assign rdata_valid = rdv_q;
    assign addr_err    = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_access_arbiter -- bench for rf_access_arbiter (default parameters).
// The bench also plays the register file: rf_rdata follows read_en and
// write_en updates its array at the clock edge. The reference model keeps
// its own copy of the register contents and a "last granted" index.
// ---------------------------------------------------------------------------
module tb_rf_access_arbiter;
  import rf_pkg::*;

  localparam int N  = 3;
  localparam int W  = 12;
  localparam int RC = 11;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_we;
  logic [4*N-1:0] req_addr;
  logic [W*N-1:0] req_wdata;
`ifdef RF_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif
  logic [N-1:0]   gnt, rdata_valid;
  logic [W-1:0]   rdata, rf_wdata, rf_rdata;
  logic           addr_err;
  logic [RC-1:0]  read_en, write_en;
  logic [1:0]     dbg_state;

  rf_access_arbiter #(.reg_count(RC), .reg_width(W), .n_req(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
`ifdef RF_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .gnt         (gnt),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .addr_err    (addr_err),
    .read_en     (read_en),
    .write_en    (write_en),
    .rf_wdata    (rf_wdata),
    .rf_rdata    (rf_rdata),
    .dbg_state   (dbg_state)
  );

  // register file stand-in
  logic [W-1:0] rf_mem [RC];
  always_comb begin
    rf_rdata = '0;
    for (int i = 0; i < RC; i++) if (read_en[i]) rf_rdata = rf_mem[i];
  end
  always @(posedge clk) begin
    for (int i = 0; i < RC; i++) if (write_en[i]) rf_mem[i] <= rf_wdata;
  end

  // reference model state
  logic [W-1:0] m_mem [RC];
  logic [W-1:0] m_rdata;
  int           m_last;
  bit           m_locked;
  int           m_owner;

  // expected / observed per cycle
  logic [N-1:0]  e_gnt, e_rdv, o_gnt, o_rdv;
  logic [RC-1:0] e_ren, e_wen, o_ren, o_wen;
  logic [W-1:0]  e_wdata, o_wdata, o_rdata;
  logic          e_err, o_err;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_reset();
    m_last   = N - 1;
    m_rdata  = '0;
    m_locked = 1'b0;
    m_owner  = 0;
  endtask

  // One cycle of the arbiter described in terms of its rules: first active
  // requester after the last winner; index must be below the entry count.
  task automatic model_step();
    int j;
    int a;
    e_gnt = '0; e_ren = '0; e_wen = '0; e_wdata = '0; e_rdv = '0; e_err = 1'b0;
    j = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (j < 0 && req_valid[c] && (!m_locked || c == m_owner)) j = c;
    end
    if (j >= 0) begin
      e_gnt[j] = 1'b1;
      a        = int'(req_addr[j*4 +: 4]);
      e_wdata  = req_wdata[j*W +: W];
      if (a < RC) begin
        if (req_we[j]) begin
          e_wen[a] = 1'b1;
          m_mem[a] = e_wdata;
        end else begin
          e_ren[a] = 1'b1;
          m_rdata  = m_mem[a];
          e_rdv[j] = 1'b1;
        end
      end else begin
        e_err = 1'b1;
      end
      m_last = j;
`ifdef RF_ARB_LOCK_EN
      if (m_locked) begin
        if (!req_lock[j]) m_locked = 1'b0;
      end else if (req_lock[j]) begin
        m_locked = 1'b1;
        m_owner  = j;
      end
`endif
    end
  endtask

  // driver: apply one cycle of requests, sample combinational outputs
  // mid-cycle and registered outputs just after the edge
  task automatic apply(input logic [N-1:0] v, input logic [N-1:0] we,
                       input logic [4*N-1:0] ad, input logic [W*N-1:0] wd);
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = ad; req_wdata = wd;
    #1;
    o_gnt = gnt; o_ren = read_en; o_wen = write_en; o_wdata = rf_wdata;
    model_step();
    @(posedge clk);
    #1;
    o_rdata = rdata; o_rdv = rdata_valid; o_err = addr_err;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 3'b111; req_we = 3'b000; req_addr = {4'd1, 4'd2, 4'd3};
    req_wdata = {12'h111, 12'h222, 12'h333};
    #1;
    n_tests++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b exp 000", gnt); end
    n_tests++; if (read_en !== '0) begin n_fail++; $display("FAIL reset_read_en got %b exp 0", read_en); end
    n_tests++; if (write_en !== '0) begin n_fail++; $display("FAIL reset_write_en got %b exp 0", write_en); end
    n_tests++; if (rf_wdata !== '0) begin n_fail++; $display("FAIL reset_rf_wdata got %h exp 0", rf_wdata); end
    n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    n_tests++; if (rdata_valid !== '0) begin n_fail++; $display("FAIL reset_rdata_valid got %b exp 0", rdata_valid); end
    n_tests++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
    n_tests++; if (dbg_state !== 2'(ST_IDLE)) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
    do_reset();
  endtask

  task automatic test_write();
    apply(3'b010, 3'b010, {4'd0, 4'd7, 4'd0}, {12'h000, 12'h0A5, 12'h000});
    n_tests++; if (o_gnt !== 3'b010) begin n_fail++; $display("FAIL wr_gnt got %b exp 010", o_gnt); end
    n_tests++; if (o_wen !== 11'b00010000000) begin n_fail++; $display("FAIL wr_write_en got %b exp 00010000000", o_wen); end
    n_tests++; if (o_ren !== '0) begin n_fail++; $display("FAIL wr_read_en got %b exp 0", o_ren); end
    n_tests++; if (o_wdata !== 12'h0A5) begin n_fail++; $display("FAIL wr_rf_wdata got %h exp 0a5", o_wdata); end
    n_tests++; if (o_rdv !== '0) begin n_fail++; $display("FAIL wr_rdata_valid got %b exp 000", o_rdv); end
    n_tests++; if (dbg_state !== 2'(ST_SERVE)) begin n_fail++; $display("FAIL wr_state got %0d exp %0d", dbg_state, ST_SERVE); end
    // read the word back through requester 2
    apply(3'b100, 3'b000, {4'd7, 4'd0, 4'd0}, '0);
    n_tests++; if (o_rdata !== 12'h0A5) begin n_fail++; $display("FAIL wr_readback got %h exp 0a5", o_rdata); end
    n_tests++; if (o_rdv !== 3'b100) begin n_fail++; $display("FAIL wr_readback_valid got %b exp 100", o_rdv); end
  endtask

  task automatic test_read();
    @(negedge clk);
    rf_mem[10] = 12'h003; m_mem[10] = 12'h003;
    apply(3'b001, 3'b000, {4'd0, 4'd0, 4'd10}, '0);
    n_tests++; if (o_gnt !== 3'b001) begin n_fail++; $display("FAIL rd_gnt got %b exp 001", o_gnt); end
    n_tests++; if (o_ren !== 11'b10000000000) begin n_fail++; $display("FAIL rd_read_en got %b exp 10000000000", o_ren); end
    n_tests++; if (o_rdata !== 12'h003) begin n_fail++; $display("FAIL rd_rdata got %h exp 003", o_rdata); end
    n_tests++; if (o_rdv !== 3'b001) begin n_fail++; $display("FAIL rd_rdata_valid got %b exp 001", o_rdv); end
    // idle cycle: valid drops, rdata holds
    apply(3'b000, 3'b000, '0, '0);
    n_tests++; if (o_gnt !== 3'b000) begin n_fail++; $display("FAIL idle_gnt got %b exp 000", o_gnt); end
    n_tests++; if ((o_ren | o_wen) !== '0) begin n_fail++; $display("FAIL idle_enables got %b/%b exp 0", o_ren, o_wen); end
    n_tests++; if (o_rdv !== 3'b000) begin n_fail++; $display("FAIL idle_rdata_valid got %b exp 000", o_rdv); end
    n_tests++; if (o_rdata !== 12'h003) begin n_fail++; $display("FAIL idle_rdata_hold got %h exp 003", o_rdata); end
    n_tests++; if (dbg_state !== 2'(ST_IDLE)) begin n_fail++; $display("FAIL idle_state got %0d exp %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order [6];
    order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(3'b111, 3'b000, {4'd2, 4'd1, 4'd0}, '0);
      n_tests++; if (o_gnt !== order[i]) begin n_fail++; $display("FAIL rr_order[%0d] got %b exp %b", i, o_gnt, order[i]); end
      n_tests++; if (o_rdv !== order[i]) begin n_fail++; $display("FAIL rr_rdata_valid[%0d] got %b exp %b", i, o_rdv, order[i]); end
    end
    // a lone requester is served every cycle
    for (int i = 0; i < 4; i++) begin
      apply(3'b010, 3'b010, {4'd0, 4'd3, 4'd0}, {12'h0, 12'(i + 12'h100), 12'h0});
      n_tests++; if (o_gnt !== 3'b010) begin n_fail++; $display("FAIL single_gnt[%0d] got %b exp 010", i, o_gnt); end
    end
  endtask

  task automatic test_addr_err();
    logic [W-1:0] held;
    held = m_rdata;
    apply(3'b100, 3'b000, {4'd12, 4'd0, 4'd0}, '0);
    n_tests++; if (o_gnt !== 3'b100) begin n_fail++; $display("FAIL err_gnt got %b exp 100", o_gnt); end
    n_tests++; if ((o_ren | o_wen) !== '0) begin n_fail++; $display("FAIL err_enables got %b/%b exp 0", o_ren, o_wen); end
    n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b exp 1", o_err); end
    n_tests++; if (o_rdv !== 3'b000) begin n_fail++; $display("FAIL err_rdata_valid got %b exp 000", o_rdv); end
    n_tests++; if (o_rdata !== held) begin n_fail++; $display("FAIL err_rdata_hold got %h exp %h", o_rdata, held); end
    apply(3'b000, 3'b000, '0, '0);
    n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL err_single_pulse got %b exp 0", o_err); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    apply(3'b001, 3'b000, {4'd0, 4'd0, 4'd2}, '0);
    @(negedge clk);
    req_valid = 3'b010; req_we = 3'b000; req_addr = {4'd0, 4'd5, 4'd0};
    #1;
    n_tests++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL midrd_gnt got %b exp 010", gnt); end
    reset = 1'b0;
    #1;
    n_tests++; if ({gnt, rdata_valid, addr_err} !== '0) begin n_fail++; $display("FAIL midrd_ctl got %b/%b/%b exp 0", gnt, rdata_valid, addr_err); end
    n_tests++; if ({read_en, write_en} !== '0) begin n_fail++; $display("FAIL midrd_enables got %b/%b exp 0", read_en, write_en); end
    n_tests++; if ({rdata, rf_wdata} !== '0) begin n_fail++; $display("FAIL midrd_data got %h/%h exp 0", rdata, rf_wdata); end
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    apply(3'b000, 3'b000, '0, '0);
    n_tests++; if (o_rdv !== 3'b000) begin n_fail++; $display("FAIL midrd_no_valid got %b exp 000", o_rdv); end
    apply(3'b111, 3'b000, {4'd1, 4'd1, 4'd1}, '0);
    n_tests++; if (o_gnt !== 3'b001) begin n_fail++; $display("FAIL midrd_next_gnt got %b exp 001", o_gnt); end
  endtask

`ifdef RF_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req_lock = 3'b010;
    apply(3'b010, 3'b000, {4'd0, 4'd4, 4'd0}, '0);
    n_tests++; if (o_gnt !== 3'b010) begin n_fail++; $display("FAIL lock_take got %b exp 010", o_gnt); end
    for (int i = 0; i < 2; i++) begin
      apply(3'b111, 3'b000, {4'd1, 4'd4, 4'd1}, '0);
      n_tests++; if (o_gnt !== 3'b010) begin n_fail++; $display("FAIL lock_hold[%0d] got %b exp 010", i, o_gnt); end
    end
    req_lock = 3'b000;
    apply(3'b111, 3'b000, {4'd1, 4'd4, 4'd1}, '0);
    n_tests++; if (o_gnt !== 3'b010) begin n_fail++; $display("FAIL lock_release got %b exp 010", o_gnt); end
    apply(3'b111, 3'b000, {4'd1, 4'd4, 4'd1}, '0);
    n_tests++; if (o_gnt !== 3'b100) begin n_fail++; $display("FAIL lock_after got %b exp 100", o_gnt); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0]   v, we;
    logic [4*N-1:0] ad;
    logic [W*N-1:0] wd;
    for (int c = 0; c < 300; c++) begin
      v  = N'($urandom_range(0, 7));
      we = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        ad[i*4 +: 4] = 4'($urandom_range(0, 12));
        wd[i*W +: W] = W'($urandom);
      end
      apply(v, we, ad, wd);
      n_tests++; if (o_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt[%0d] got %b exp %b", c, o_gnt, e_gnt); end
      n_tests++; if (o_ren !== e_ren) begin n_fail++; $display("FAIL rnd_read_en[%0d] got %b exp %b", c, o_ren, e_ren); end
      n_tests++; if (o_wen !== e_wen) begin n_fail++; $display("FAIL rnd_write_en[%0d] got %b exp %b", c, o_wen, e_wen); end
      n_tests++; if (o_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_rf_wdata[%0d] got %h exp %h", c, o_wdata, e_wdata); end
      n_tests++; if (o_rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d] got %h exp %h", c, o_rdata, m_rdata); end
      n_tests++; if (o_rdv !== e_rdv) begin n_fail++; $display("FAIL rnd_rdata_valid[%0d] got %b exp %b", c, o_rdv, e_rdv); end
      n_tests++; if (o_err !== e_err) begin n_fail++; $display("FAIL rnd_addr_err[%0d] got %b exp %b", c, o_err, e_err); end
    end
  endtask

  initial begin
    logic [W-1:0] seed_val;
`ifdef RF_ARB_LOCK_EN
    req_lock = '0;
`endif
    for (int i = 0; i < RC; i++) begin
      seed_val  = W'($urandom);
      rf_mem[i] = seed_val;
      m_mem[i]  = seed_val;
    end
    model_reset();
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_addr_err();
    test_reset_mid_read();
`ifdef RF_ARB_LOCK_EN
    test_lock();
    req_lock = '0;
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
